// File: rtl/door_debouncer_if.sv
// Door contact bundle: raw switch in, debounced level, edge pulses and opening count out.
interface door_debouncer_if;
  logic       door_sw;
  logic       door_open;
  logic       opened_pulse;
  logic       closed_pulse;
  logic [7:0] open_count;

  modport master (
    output door_sw,
    input  door_open,
    input  opened_pulse,
    input  closed_pulse,
    input  open_count
  );

  modport slave (
    input  door_sw,
    output door_open,
    output opened_pulse,
    output closed_pulse,
    output open_count
  );
endinterface

// File: rtl/door_debouncer.sv
// Door contact synchroniser + per-transition debounce FSM with open/close pulses.
// DOOR_EVENT_CNT_EN adds a saturating count of debounced openings on open_count.
module door_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  door_debouncer_if.slave dif
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    CLOSED,
    OPEN_PEND,
    OPEN,
    CLOSE_PEND
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   open_q;
  logic                   opened_q;
  logic                   closed_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], dif.door_sw};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Pulses default low every cycle so each lasts exactly one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= CLOSED;
      cnt_q    <= '0;
      open_q   <= 1'b0;
      opened_q <= 1'b0;
      closed_q <= 1'b0;
    end else begin
      opened_q <= 1'b0;
      closed_q <= 1'b0;
      unique case (state_q)
        CLOSED: begin
          if (s) begin
            state_q <= OPEN_PEND;
            cnt_q   <= CNT_ONE;
          end
        end
        OPEN_PEND: begin
          if (!s) begin
            state_q <= CLOSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= OPEN;
            open_q   <= 1'b1;
            opened_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        OPEN: begin
          if (!s) begin
            state_q <= CLOSE_PEND;
            cnt_q   <= CNT_ONE;
          end
        end
        CLOSE_PEND: begin
          if (s) begin
            state_q <= OPEN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= CLOSED;
            open_q   <= 1'b0;
            closed_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= CLOSED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign dif.door_open    = open_q;
  assign dif.opened_pulse = opened_q;
  assign dif.closed_pulse = closed_q;

`ifdef DOOR_EVENT_CNT_EN
  logic [7:0] evt_q, evt_d;

  always_comb begin
    evt_d = evt_q;
    if (opened_q && (evt_q != 8'hFF)) begin
      evt_d = evt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      evt_q <= 8'h00;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign dif.open_count = evt_q;
`else
  assign dif.open_count = 8'h00;
`endif
endmodule

// File: tb/tb_door_debouncer.sv
// Randomised and directed bench for door_debouncer against a run-length model.
`timescale 1ns/100ps
module tb_door_debouncer;
  localparam int SYNC = 2;
  localparam int DEB  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  door_debouncer_if dif ();

  door_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dif  (dif.slave)
  );

  always #1 clock = ~clock;

  // Model: the debounced level flips once DEB consecutive
  // synchronised samples disagree with it.
  bit       sq [SYNC];
  bit       m_open = 1'b0;
  bit       m_op = 1'b0;
  bit       m_cp = 1'b0;
  int       run = 0;
  bit [7:0] m_cnt = 8'h00;

  always @(posedge clock or negedge reset) begin
    bit s;
    if (!reset) begin
      foreach (sq[i]) sq[i] = 1'b0;
      m_open = 1'b0;
      m_op   = 1'b0;
      m_cp   = 1'b0;
      run    = 0;
      m_cnt  = 8'h00;
    end else begin
`ifdef DOOR_EVENT_CNT_EN
      if (m_op && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
`endif
      s = sq[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) sq[i] = sq[i-1];
      sq[0] = dif.door_sw;
      m_op = 1'b0;
      m_cp = 1'b0;
      run  = (s != m_open) ? run + 1 : 0;
      if (run == DEB) begin
        m_open = s;
        run    = 0;
        if (s) m_op = 1'b1;
        else   m_cp = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    checks++;
    if (dif.door_open !== m_open || dif.opened_pulse !== m_op ||
        dif.closed_pulse !== m_cp || dif.open_count !== m_cnt) begin
      errors++;
      $display("FAIL model t=%0t got open=%b op=%b cp=%b cnt=%0d exp %b %b %b %0d",
               $time, dif.door_open, dif.opened_pulse, dif.closed_pulse,
               dif.open_count, m_open, m_op, m_cp, m_cnt);
    end
    if (dif.opened_pulse === 1'b1 && dif.closed_pulse === 1'b1) begin
      errors++;
      $display("FAIL both_pulses t=%0t", $time);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input bit sw, input int cyc);
    #0.5 reset = 1'b0;
    dif.door_sw = sw;
    repeat (cyc) @(negedge clock);
    #0.5 reset = 1'b1;
  endtask

  initial begin
    bit pat [5];
    int npulse, at_edge, bad;
    int exp_cnt;
    dif.door_sw = 1'b0;
    #0.3 reset = 1'b0;
    #30;
    chk("rst_open", int'(dif.door_open), 0);
    chk("rst_pulses", int'(dif.opened_pulse | dif.closed_pulse), 0);
    chk("rst_cnt", int'(dif.open_count), 0);
    @(negedge clock);
    #0.5 reset = 1'b1;
    dif.door_sw = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      step();
      if (e == 9)  chk("open_e9", int'(dif.door_open), 0);
      if (e == 10) begin
        chk("open_e10", int'(dif.door_open), 1);
        chk("oppulse_e10", int'(dif.opened_pulse), 1);
        chk("model_e10", int'(m_open), 1);
      end
      if (e == 11) chk("oppulse_e11", int'(dif.opened_pulse), 0);
    end
    exp_cnt = 0;
`ifdef DOOR_EVENT_CNT_EN
    exp_cnt = 1;
`endif
    chk("cnt_first", int'(dif.open_count), exp_cnt);

    bad = 0;
    dif.door_sw = 1'b0;
    repeat (5) begin
      step();
      if (dif.closed_pulse || !dif.door_open) bad++;
    end
    dif.door_sw = 1'b1;
    repeat (12) begin
      step();
      if (dif.closed_pulse || !dif.door_open) bad++;
    end
    chk("glitch5_held", bad, 0);

    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    foreach (pat[i]) begin
      dif.door_sw = pat[i];
      step();
    end
    dif.door_sw = 1'b0;
    npulse = 0;
    at_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (dif.closed_pulse) begin
        npulse++;
        at_edge = e;
      end
    end
    chk("bounce_npulse", npulse, 1);
    chk("bounce_edge", at_edge, 10);
    chk("bounce_closed", int'(dif.door_open), 0);
    chk("model_closed", int'(m_open), 0);

    dif.door_sw = 1'b1;
    repeat (6) step();
    #0.5 reset = 1'b0;
    dif.door_sw = 1'b0;
    #0.1;
    chk("midrst_open", int'(dif.door_open), 0);
    chk("midrst_pulse", int'(dif.opened_pulse | dif.closed_pulse), 0);
    @(negedge clock);
    repeat (2) @(negedge clock);
    #0.5 reset = 1'b1;
    npulse = 0;
    repeat (20) begin
      step();
      if (dif.opened_pulse || dif.closed_pulse || dif.door_open) npulse++;
    end
    chk("after_rst_quiet", npulse, 0);

    @(negedge clock);
    do_reset(1'b1, 3);
    at_edge = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (dif.opened_pulse) at_edge = e;
    end
    chk("rel_high_edge", at_edge, 10);

    repeat (400) begin
      int len;
      dif.door_sw = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      repeat (len) step();
      if ($urandom_range(0, 39) == 0) begin
        do_reset(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        @(negedge clock);
      end
    end

    dif.door_sw = 1'b0;
    repeat (12) step();
    do_reset(1'b0, 2);
    @(negedge clock);
    for (int k = 1; k <= 257; k++) begin
      dif.door_sw = 1'b1;
      repeat (12) step();
`ifdef DOOR_EVENT_CNT_EN
      exp_cnt = (k > 255) ? 255 : k;
`else
      exp_cnt = 0;
`endif
      if (k == 1 || k == 255 || k == 257)
        chk($sformatf("cnt_open%0d", k), int'(dif.open_count), exp_cnt);
      dif.door_sw = 1'b0;
      repeat (12) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
